sr_pulse_driver: RTL and testbench
==================================

# sr_pulse_driver

Clocked driver for the set/reset input pair of an SR latch (NOR form, active-high S/R). Accepts set/reset/toggle commands over a valid/ready handshake and produces a clean S or R pulse of programmable width. S and R are never asserted together, and a guard gap follows every pulse. It then samples the latch's Q/Qbar feedback and reports completion plus any mismatch or forbidden-state error. It is the transmitting end of the S/R interface, sitting between control logic and a latch instance.

## Interface
- WIDTH_W, 8: width of the pulse-length field.
- GAP, 2: idle cycles with S=R=0 after each pulse, before the check; legal range is ≥1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  driver can accept a command; high only in IDLE.
- cmd_op  input  2  00 NOP, 01 SET, 10 RESET, 11 TOGGLE.
- cmd_width  input  WIDTH_W  pulse length in cycles; 0 is treated as 1.
- q  input  1  latch Q feedback.
- q_bar  input  1  latch Qbar feedback.
- s  output  1  latch set drive, registered.
- r  output  1  latch reset drive, registered.
- busy  output  1  high when the state is not IDLE.
- done  output  1  one-cycle pulse when a command completes.
- err  output  1  one-cycle pulse coincident with done: Q did not reach its expected value.
- err_invalid  output  1  one-cycle pulse coincident with done: q==q_bar was sampled at check.

## Operation
- States:
  - IDLE: waits for a command. Handshake completes when cmd_valid && cmd_ready.
  - PULSE: drives s or r; a down counter is loaded with max(cmd_width,1).
  - GAP: drives s=r=0 for GAP cycles.
  - CHECK: one cycle; raises done and the error flags; returns to IDLE.
- Op resolution is captured at acceptance:
  - SET: drives s; expected Q=1.
  - RESET: drives r; expected Q=0.
  - TOGGLE: uses q sampled at acceptance. q=1 resolves to RESET; q=0 resolves to SET. If q==q_bar at acceptance, it resolves to SET.
  - NOP: IDLE→CHECK directly with no pulse; err=0; err_invalid is still evaluated.
- The expected value and the resolved op are latched at acceptance. cmd_* inputs are ignored while busy.
- At CHECK:
  - err = (q != expected).
  - err_invalid = (q == q_bar).
  - Both flags may assert together.
- Invariant: s && r is never 1 in any cycle.
- Reset, at any time including mid-pulse:
  - s=0, r=0, done=0, err=0, err_invalid=0, busy=0; state is IDLE.
  - cmd_ready=1 from the first clock after reset deasserts.
  - An aborted command produces no done.

## Timing
- Reset values: s=0, r=0, busy=0, done=0, err=0, err_invalid=0, cmd_ready=1.
- Acceptance at edge k, pulse width W=max(cmd_width,1):
  - s (or r) is high for cycles k+1 … k+W.
  - s=r=0 for cycles k+W+1 … k+W+GAP.
  - done and the error flags are high in cycle k+W+GAP+1.
  - cmd_ready returns high in cycle k+W+GAP+2.
- NOP accepted at edge k: done is high in cycle k+1; cmd_ready is high in k+2.
- Back-to-back commands: the earliest next acceptance is the first cycle cmd_ready is high. There is no zero-bubble overlap with done.
- Counter: WIDTH_W bits, counts down, loaded with W and ending at 1. A cmd_width of all-ones gives 2^WIDTH_W−1 cycles with no wrap.
- Feedback: q/q_bar are sampled directly with no synchronizer, because the latch is driven only from these registers in the same clock domain. GAP covers latch settling.

## Structure
- Package sr_pkg holds:
  - the op encoding constants (OP_NOP, OP_SET, OP_RESET, OP_TOGGLE);
  - the state encoding (ST_IDLE, ST_PULSE, ST_GAP, ST_CHECK).
- One sub-module, sr_pulse_counter: a loadable down counter with a "last" flag, reused for both the PULSE and GAP phases.

## Test plan
- After reset, drive SET with width 3 and GAP=2. Required: s=1 for exactly 3 cycles and r=0 throughout; done in cycle 6 after acceptance; err=0 with a real latch connected.
- From Q=1, TOGGLE with width 1. Required: r pulses for 1 cycle; Q becomes 0; done follows with err=0.
- Tie q=0 and q_bar=1, then issue SET with width 2. Required: err=1 with done; err_invalid=0.
- Tie q=q_bar=1, then issue NOP. Required: done one cycle after acceptance; err_invalid=1; s=r=0 throughout.
- Assert rst in the second cycle of a SET with width 5. Required: s drops immediately (asynchronously); no done; cmd_ready=1 after release.
- Issue cmd_width=0, then hold cmd_valid high for back-to-back SET then RESET. Required: width-1 pulses; s && r never high together; second acceptance only after the first done.

Source files
------------

// File: rtl/sr_pkg.sv
// sr_pkg: op and state encodings for the S/R latch pulse driver.
package sr_pkg;
    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_RESET  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PULSE = 2'b01;
    localparam logic [1:0] ST_GAP   = 2'b10;
    localparam logic [1:0] ST_CHECK = 2'b11;

    // A toggle only becomes RESET from a clean Q=1; a forbidden or low Q resolves to SET.
    function automatic logic [1:0] resolve_op(input logic [1:0] op, input logic q, input logic q_bar);
        return op == OP_TOGGLE ? ((q && !q_bar) ? OP_RESET : OP_SET) : op;
    endfunction
endpackage

// File: rtl/sr_pulse_driver_if.sv
// sr_pulse_driver_if: command handshake between control logic and the pulse driver.
interface sr_pulse_driver_if #(
    parameter int WIDTH_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [WIDTH_W-1:0] cmd_width;

    modport master (output cmd_valid, cmd_op, cmd_width, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_width, output cmd_ready);
endinterface

// File: rtl/sr_pulse_counter.sv
// sr_pulse_counter: loadable down counter flagging its final cycle, shared by pulse and gap phases.
module sr_pulse_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         last
);
    logic [W-1:0] count;

    assign last = count <= W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (load) count <= load_val;
        else if (en && !last) count <= count - 1'b1;
    end
endmodule

// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: handshake-driven S/R latch pulse generator with guard gap and Q/Qbar check.
module sr_pulse_driver
    import sr_pkg::*;
#(
    parameter int WIDTH_W = 8,
    parameter int GAP     = 2
) (
    input  logic             clk,
    input  logic             rst,
    sr_pulse_driver_if.slave cmd,
    input  logic             q,
    input  logic             q_bar,
    output logic             s,
    output logic             r,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             err_invalid
);
    localparam int GW = $clog2(GAP + 1);
    localparam int CW = WIDTH_W > GW ? WIDTH_W : GW;

    logic [1:0]    state, op_q, op_res;
    logic          expected, accept, load, last, cnt_en;
    logic [CW-1:0] load_val;

    assign cmd.cmd_ready = state == ST_IDLE;
    assign accept        = cmd.cmd_ready && cmd.cmd_valid;
    assign op_res        = resolve_op(cmd.cmd_op, q, q_bar);
    assign load          = (accept && op_res != OP_NOP) || (state == ST_PULSE && last);
    assign cnt_en        = state == ST_PULSE || state == ST_GAP;
    // The same counter times the pulse (width 0 stretched to 1) and then the guard gap.
    assign load_val      = state == ST_IDLE ? (cmd.cmd_width == '0 ? CW'(1) : CW'(cmd.cmd_width))
                                            : CW'(GAP);

    sr_pulse_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .en       (cnt_en),
        .load_val (load_val),
        .last     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_NOP;
            expected <= 1'b0;
            s        <= 1'b0;
            r        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    state    <= op_res == OP_NOP ? ST_CHECK : ST_PULSE;
                    op_q     <= op_res;
                    expected <= op_res == OP_SET;
                    s        <= op_res == OP_SET;
                    r        <= op_res == OP_RESET;
                end
                ST_PULSE: if (last) begin
                    state <= ST_GAP;
                    s     <= 1'b0;
                    r     <= 1'b0;
                end
                ST_GAP:   if (last) state <= ST_CHECK;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = state != ST_IDLE;
    assign done        = state == ST_CHECK;
    assign err         = done && op_q != OP_NOP && q != expected;
    assign err_invalid = done && q == q_bar;
endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb_sr_pulse_driver: randomized and directed checks of sr_pulse_driver against a cycle-count model.
module tb_sr_pulse_driver;
    import sr_pkg::*;

    localparam int WW   = 8;
    localparam int G    = 2;
    localparam int MAXC = 300;

    logic clk = 1'b0;
    logic rst;
    logic q, q_bar, s, r, busy, done, err, err_invalid;
    logic tie, tie_q, tie_qb;
    logic q_l = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic cap_s [0:MAXC];
    logic cap_r [0:MAXC];
    logic cap_done [0:MAXC];
    logic cap_err [0:MAXC];
    logic cap_inv [0:MAXC];
    logic cap_rdy [0:MAXC];
    logic acc_q, acc_qb;

    always #5 clk = ~clk;

    sr_pulse_driver_if #(.WIDTH_W(WW)) cmd ();

    sr_pulse_driver #(.WIDTH_W(WW), .GAP(G)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd),
        .q           (q),
        .q_bar       (q_bar),
        .s           (s),
        .r           (r),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_invalid (err_invalid)
    );

    // Behavioural NOR latch, overridable by forced feedback values.
    always @(posedge s or posedge r) q_l <= s;
    assign q     = tie ? tie_q  : q_l;
    assign q_bar = tie ? tie_qb : ~q_l;

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (s && r) begin
                errors++;
                $display("FAIL s_r_exclusive: s=%b r=%b at %0t, want not both high", s, r, $time);
            end
        end
    end

    function automatic int wval(input logic [WW-1:0] w);
        return w == 0 ? 1 : int'(w);
    endfunction

    function automatic logic res_set(input logic [1:0] op, input logic qa, input logic qba);
        return op == OP_SET || (op == OP_TOGGLE && !(qa && !qba));
    endfunction

    // Issues one command from a negedge and records ncap cycles after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [WW-1:0] w, input int ncap);
        int t = 0;
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = op;
        cmd.cmd_width = w;
        while (!cmd.cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 50) begin
            errors++;
            $display("FAIL accept_timeout: ready=%b after %0d cycles, want 1", cmd.cmd_ready, t);
        end
        acc_q  = q;
        acc_qb = q_bar;
        @(posedge clk);
        #1 cmd.cmd_valid = 1'b0;
        for (int c = 1; c <= ncap; c++) begin
            @(negedge clk);
            cap_s[c] = s; cap_r[c] = r; cap_done[c] = done;
            cap_err[c] = err; cap_inv[c] = err_invalid; cap_rdy[c] = cmd.cmd_ready;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tie = 1'b0; tie_q = 1'b0; tie_qb = 1'b0;
        cmd.cmd_valid = 1'b0; cmd.cmd_op = OP_NOP; cmd.cmd_width = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({s, r, busy, done, err, err_invalid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: s,r,busy,done,err,inv=%b want 000000", {s, r, busy, done, err, err_invalid});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: ready=%b busy=%b want 1 0", cmd.cmd_ready, busy);
        end
    endtask

    task automatic test_set_pulse();
        int n = 3 + G + 2;
        send(OP_SET, 8'd3, n);
        for (int c = 1; c <= n; c++) begin
            logic [3:0] want;
            want = {c <= 3, 1'b0, c == 3 + G + 1, c >= 3 + G + 2};
            checks++;
            if ({cap_s[c], cap_r[c], cap_done[c], cap_rdy[c]} !== want) begin
                errors++;
                $display("FAIL set_cycle%0d: s,r,done,rdy=%b want %b", c, {cap_s[c], cap_r[c], cap_done[c], cap_rdy[c]}, want);
            end
        end
        checks++;
        if (cap_err[3 + G + 1] !== 1'b0 || q !== 1'b1) begin
            errors++;
            $display("FAIL set_result: err=%b q=%b want err=0 q=1", cap_err[3 + G + 1], q);
        end
    endtask

    task automatic test_toggle();
        int rs = 0, ss = 0;
        send(OP_TOGGLE, 8'd1, 5);
        for (int c = 1; c <= 5; c++) begin rs += int'(cap_r[c]); ss += int'(cap_s[c]); end
        checks++;
        if (cap_r[1] !== 1'b1 || rs != 1 || ss != 0) begin
            errors++;
            $display("FAIL toggle_pulse: r1=%b r_cycles=%0d s_cycles=%0d want 1 1 0", cap_r[1], rs, ss);
        end
        checks++;
        if (cap_done[4] !== 1'b1 || cap_err[4] !== 1'b0 || q !== 1'b0) begin
            errors++;
            $display("FAIL toggle_done: done=%b err=%b q=%b want 1 0 0", cap_done[4], cap_err[4], q);
        end
    endtask

    task automatic test_err_flags();
        tie = 1'b1; tie_q = 1'b0; tie_qb = 1'b1;
        send(OP_SET, 8'd2, 6);
        checks++;
        if ({cap_done[5], cap_err[5], cap_inv[5]} !== 3'b110) begin
            errors++;
            $display("FAIL err_stuck_q: done,err,inv=%b want 110", {cap_done[5], cap_err[5], cap_inv[5]});
        end
        tie = 1'b0;
    endtask

    task automatic test_nop_invalid();
        tie = 1'b1; tie_q = 1'b1; tie_qb = 1'b1;
        send(OP_NOP, 8'd7, 3);
        checks++;
        if ({cap_done[1], cap_err[1], cap_inv[1], cap_done[2], cap_rdy[2]} !== 5'b10101) begin
            errors++;
            $display("FAIL nop_invalid: done1,err1,inv1,done2,rdy2=%b want 10101",
                     {cap_done[1], cap_err[1], cap_inv[1], cap_done[2], cap_rdy[2]});
        end
        checks++;
        if ({cap_s[1], cap_r[1], cap_s[2], cap_r[2], cap_s[3], cap_r[3]} !== 6'b0) begin
            errors++;
            $display("FAIL nop_no_pulse: s/r trace=%b want 000000", {cap_s[1], cap_r[1], cap_s[2], cap_r[2], cap_s[3], cap_r[3]});
        end
        tie = 1'b0;
    endtask

    task automatic test_reset_abort();
        int dn = 0;
        cmd.cmd_valid = 1'b1; cmd.cmd_op = OP_SET; cmd.cmd_width = 8'd5;
        @(posedge clk);
        #1 cmd.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (s !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: s=%b want 1", s);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (s !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: s=%b busy=%b want 0 0", s, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            dn += int'(done);
        end
        checks++;
        if (dn != 0 || cmd.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_done: done_cycles=%0d ready=%b want 0 1", dn, cmd.cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        int acc1 = -1, acc2 = -1, d1 = -1, sc = 0, rc = 0;
        cmd.cmd_valid = 1'b1; cmd.cmd_op = OP_SET; cmd.cmd_width = '0;
        for (int i = 0; i < 20; i++) begin
            if (cmd.cmd_ready && cmd.cmd_valid) begin
                if (acc1 < 0) acc1 = i;
                else if (acc2 < 0) acc2 = i;
            end
            if (done && d1 < 0) d1 = i;
            sc += int'(s);
            rc += int'(r);
            @(posedge clk);
            #1;
            if (acc1 >= 0) cmd.cmd_op = OP_RESET;
            if (acc2 >= 0) cmd.cmd_valid = 1'b0;
            @(negedge clk);
        end
        cmd.cmd_valid = 1'b0;
        checks++;
        if (d1 != acc1 + 1 + G + 1 || acc2 != d1 + 1) begin
            errors++;
            $display("FAIL b2b_timing: acc1=%0d done1=%0d acc2=%0d want done1=acc1+%0d acc2=done1+1", acc1, d1, acc2, G + 2);
        end
        checks++;
        if (sc != 1 || rc != 1) begin
            errors++;
            $display("FAIL b2b_widths: s_cycles=%0d r_cycles=%0d want 1 1", sc, rc);
        end
    endtask

    task automatic test_max_width();
        int sc = 0, dc = -1;
        send(OP_SET, 8'hFF, 255 + G + 2);
        for (int c = 1; c <= 255 + G + 2; c++) begin
            sc += int'(cap_s[c]);
            if (cap_done[c] && dc < 0) dc = c;
        end
        checks++;
        if (sc != 255 || dc != 255 + G + 1) begin
            errors++;
            $display("FAIL max_width: s_cycles=%0d done_cycle=%0d want 255 %0d", sc, dc, 255 + G + 1);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            logic [1:0]    op;
            logic [WW-1:0] w;
            logic          st, qchk;
            int            wd, d;
            op  = 2'($urandom_range(0, 3));
            w   = WW'($urandom_range(0, 6));
            tie = $urandom_range(0, 3) == 0;
            tie_q = 1'($urandom); tie_qb = 1'($urandom);
            #1;
            wd = op == OP_NOP ? 0 : wval(w);
            d  = op == OP_NOP ? 1 : wd + G + 1;
            send(op, w, d + 1);
            st   = res_set(op, acc_q, acc_qb);
            qchk = tie ? tie_q : (op == OP_NOP ? acc_q : st);
            for (int c = 1; c <= d + 1; c++) begin
                logic [3:0] want;
                want = {op != OP_NOP && st && c <= wd, op != OP_NOP && !st && c <= wd, c == d, c > d};
                checks++;
                if ({cap_s[c], cap_r[c], cap_done[c], cap_rdy[c]} !== want) begin
                    errors++;
                    $display("FAIL rand%0d_cycle%0d op=%0d w=%0d: s,r,done,rdy=%b want %b", it, c, op, w,
                             {cap_s[c], cap_r[c], cap_done[c], cap_rdy[c]}, want);
                end
            end
            checks++;
            if ({cap_err[d], cap_inv[d]} !== {op != OP_NOP && qchk != st, tie && tie_q == tie_qb}) begin
                errors++;
                $display("FAIL rand%0d_flags op=%0d tie=%b: err,inv=%b want %b", it, op, tie, {cap_err[d], cap_inv[d]},
                         {op != OP_NOP && qchk != st, tie && tie_q == tie_qb});
            end
            tie = 1'b0;
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_set_pulse();
        test_toggle();
        test_err_flags();
        test_nop_invalid();
        test_reset_abort();
        test_back_to_back();
        test_max_width();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
